// File: rtl/sha_padder.sv
// sha_padder: streaming SHA-256 message padder. Collects message bytes into
// 512-bit blocks, appends 0x80, zero fill and the 64-bit big-endian bit
// length, and presents finished blocks over a valid/ready handshake.
module sha_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  output logic         blk_last,
  input  logic         blk_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_PAD    = 2'd1,
    S_EMIT   = 2'd2,
    S_LENBLK = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] BYTE_BITS = LEN_W'(8);

  state_t             state_q, state_d;
  logic [511:0]       buf_q, buf_d;
  logic [6:0]         p_q, p_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               extra_q, extra_d;
  logic               last_q, last_d;
  logic               nxt_len_q, nxt_len_d;
  logic               busy_q, busy_d;
  logic [63:0]        len64;

  // Place a byte at byte position pos (byte 0 occupies bits [511:504]).
  function automatic logic [511:0] place(input logic [7:0] b, input logic [6:0] pos);
    place = {b, 504'b0} >> {pos, 3'b000};
  endfunction

  assign len64 = 64'(cnt_q);

  // Next-state, buffer and counter update for the padding FSM.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    extra_d   = extra_q;
    last_d    = last_q;
    nxt_len_d = nxt_len_q;
    busy_d    = busy_q;
    case (state_q)
      S_ACCEPT: begin
        if (in_valid) begin
          if (!in_empty) begin
            buf_d  = buf_q | place(in_data, p_q);
            p_d    = p_q + 7'd1;
            cnt_d  = cnt_q + BYTE_BITS;
            busy_d = 1'b1;
          end
          if (in_last) begin
            state_d = S_PAD;
            busy_d  = 1'b1;
          end else if (!in_empty && p_q == 7'd63) begin
            state_d   = S_EMIT;
            last_d    = 1'b0;
            nxt_len_d = 1'b0;
          end
        end
      end
      S_PAD: begin
        state_d = S_EMIT;
        if (p_q == 7'd64) begin
          // Block is full: the 0x80 marker moves into the length block.
          extra_d   = 1'b1;
          last_d    = 1'b0;
          nxt_len_d = 1'b1;
        end else begin
          buf_d = buf_q | place(8'h80, p_q);
          if (p_q <= 7'd55) begin
            buf_d[63:0] = len64;
            last_d      = 1'b1;
            nxt_len_d   = 1'b0;
          end else begin
            last_d    = 1'b0;
            nxt_len_d = 1'b1;
          end
        end
      end
      S_LENBLK: begin
        buf_d     = {(extra_q ? 8'h80 : 8'h00), 440'b0, len64};
        last_d    = 1'b1;
        nxt_len_d = 1'b0;
        state_d   = S_EMIT;
      end
      S_EMIT: begin
        if (blk_ready) begin
          buf_d     = '0;
          p_d       = 7'd0;
          last_d    = 1'b0;
          nxt_len_d = 1'b0;
          if (last_q) begin
            state_d = S_ACCEPT;
            cnt_d   = '0;
            extra_d = 1'b0;
            busy_d  = 1'b0;
          end else if (nxt_len_q) begin
            state_d = S_LENBLK;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      default: state_d = S_ACCEPT;
    endcase
  end

  // State and datapath registers; reset aborts any message in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ACCEPT;
      buf_q     <= '0;
      p_q       <= 7'd0;
      cnt_q     <= '0;
      extra_q   <= 1'b0;
      last_q    <= 1'b0;
      nxt_len_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      extra_q   <= extra_d;
      last_q    <= last_d;
      nxt_len_q <= nxt_len_d;
      busy_q    <= busy_d;
    end
  end

  // in_ready is held low while reset is asserted even though the state sits in ACCEPT.
  assign in_ready  = rst_n & (state_q == S_ACCEPT);
  assign blk_valid = (state_q == S_EMIT);
  assign blk_data  = buf_q;
  assign blk_last  = last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sha_padder.sv
// tb_sha_padder: directed bench for sha_padder with a block scoreboard fed
// by an independent FIPS 180-4 padding model.
module tb_sha_padder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]   msg[$];
  logic [511:0] sb_d[$];
  logic         sb_l[$];

  always #5 clk = ~clk;

  sha_padder #(.LEN_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_empty(in_empty),
    .in_ready(in_ready),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic build_exp();
    logic [7:0]   pad[$];
    logic [63:0]  len;
    logic [511:0] d;
    int           nb;
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    len = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) pad.push_back(len[8*k +: 8]);
    nb = pad.size() / 64;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int j = 0; j < 64; j++) d[511-8*j -: 8] = pad[64*b+j];
      sb_d.push_back(d);
      sb_l.push_back(b == nb - 1);
    end
  endtask

  // Drive one beat and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] b, input logic last, input logic empty);
    int n = 0;
    in_data = b; in_last = last; in_empty = empty; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 512'(in_ready), 512'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0; in_data = 8'h00;
  endtask

  task automatic send_msg(input bit empty_last);
    build_exp();
    for (int i = 0; i < msg.size(); i++)
      send(msg[i], (i == msg.size() - 1) && !empty_last, 1'b0);
    if (empty_last || msg.size() == 0) send(8'h00, 1'b1, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb_d.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 512'(sb_d.size()), 512'(0));
    @(posedge clk);
    #1;
    chk({tag, "_busy_idle"}, 512'(busy), 512'(1'b0));
  endtask

  // Scoreboard: compare each block at the handshake against the model.
  always @(negedge clk) begin
    if (rst_n && blk_valid && blk_ready) begin
      if (sb_d.size() == 0) begin
        chk("unexpected_block", 512'(blk_valid), 512'(1'b0));
      end else begin
        chk("blk_data", blk_data, sb_d.pop_front());
        chk("blk_last", 512'(blk_last), 512'(sb_l.pop_front()));
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    blk_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'(1'b0));
    chk("rst_blk_valid", 512'(blk_valid), 512'(1'b0));
    chk("rst_blk_last", 512'(blk_last), 512'(1'b0));
    chk("rst_blk_data", blk_data, 512'(0));
    chk("rst_busy", 512'(busy), 512'(1'b0));
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 512'(in_ready), 512'(1'b1));
    @(posedge clk);
    #1;

    // "abc"
    msg = '{8'h61, 8'h62, 8'h63};
    build_exp();
    send(8'h61, 1'b0, 1'b0);
    chk("abc_busy", 512'(busy), 512'(1'b1));
    send(8'h62, 1'b0, 1'b0);
    send(8'h63, 1'b1, 1'b0);
    wait_drain("abc");

    // Empty message
    msg.delete();
    send_msg(1'b1);
    wait_drain("empty");

    // 55 zero bytes: padding fits in the same block
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'h00);
    send_msg(1'b0);
    wait_drain("len55");

    // 56 bytes: length spills into a second block
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'(i + 1));
    send_msg(1'b0);
    wait_drain("len56");

    // 64 bytes then an empty last beat
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'(8'hA0 ^ i));
    send_msg(1'b1);
    wait_drain("len64");

    // Backpressure on a full block, then reset mid-message
    blk_ready = 1'b0;
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'(3 * i + 1));
    build_exp();
    void'(sb_d.pop_back());
    void'(sb_l.pop_back());
    for (int i = 0; i < 64; i++) send(msg[i], 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!blk_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_rise", 512'(blk_valid), 512'(1'b1));
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid_hold", 512'(blk_valid), 512'(1'b1));
      chk("bp_data_hold", blk_data, sb_d[0]);
      chk("bp_last_hold", 512'(blk_last), 512'(1'b0));
      chk("bp_in_ready_low", 512'(in_ready), 512'(1'b0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    blk_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(8'(8'h50 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 512'(in_ready), 512'(1'b0));
    chk("midrst_blk_valid", 512'(blk_valid), 512'(1'b0));
    chk("midrst_blk_last", 512'(blk_last), 512'(1'b0));
    chk("midrst_blk_data", blk_data, 512'(0));
    chk("midrst_busy", 512'(busy), 512'(1'b0));
    chk("bp_block_seen", 512'(sb_d.size()), 512'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("postrst_no_block", 512'(blk_valid), 512'(1'b0));
    end
    @(posedge clk);
    #1;

    // "abc" again with an ignored empty non-last beat in the middle
    msg = '{8'h61, 8'h62, 8'h63};
    build_exp();
    send(8'h61, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b1);
    send(8'h62, 1'b0, 1'b0);
    send(8'h63, 1'b1, 1'b0);
    wait_drain("abc2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha_padder.md
# sha_padder

Streaming message padder for the SHA-256 datapath. It accepts message bytes over a valid/ready handshake and assembles them into 512-bit blocks. It appends the FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. Blocks are presented over a second valid/ready handshake, and a last-block flag goes to the compression core directly downstream.

## Interface
- LEN_W, 64: width of the internal bit-length counter. Legal range 16..64. The value is zero-extended into the 64-bit length field.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  8  message byte.
- in_valid  in  1  in_data/in_last/in_empty are valid.
- in_last  in  1  this beat ends the message.
- in_empty  in  1  only meaningful with in_last. The beat carries no byte, which permits zero-length messages and ending after a full block.
- in_ready  out  1  padder accepts a beat this cycle.
- blk_data  out  512  block. Message byte 0 is at [511:504] (big-endian words, word 0 at MSBs).
- blk_valid  out  1  blk_data/blk_last are valid.
- blk_last  out  1  final block of the message.
- blk_ready  in  1  downstream consumes the block this cycle.
- busy  out  1  high from first accepted beat until the final block handshake.

## Operation
- Registers:
  - 512-bit block buffer.
  - 7-bit byte pointer p (0..64).
  - LEN_W bit counter (adds 8 per byte, wraps mod 2^LEN_W).
  - `extra` flag.
- States: ACCEPT, PAD, EMIT, LENBLK.
- ACCEPT:
  - in_ready=1.
  - Beat accepted when in_valid&in_ready.
  - A non-empty beat writes the byte at position p, increments p and adds 8 to the counter.
  - If the beat is not last and p becomes 64: go to EMIT with blk_last=0, then return to ACCEPT with the buffer zeroed and p=0.
  - If the beat is last (empty or not): go to PAD.
- PAD (one cycle, in_ready=0):
  - If p==64: emit the current full block with blk_last=0 and set `extra`. The next block is then built with 0x80 at byte 0, zeros, and the length at [63:0].
  - Otherwise write 0x80 at p; bytes p+1..63 are already zero.
  - If p<=55: write the length into bytes 56..63 and go to EMIT with blk_last=1.
  - If p>=56: go to EMIT with blk_last=0, then LENBLK.
- LENBLK (one cycle): build a block that is zero except for the length field (plus 0x80 at byte 0 if `extra`), then go to EMIT with blk_last=1.
- EMIT:
  - blk_valid=1; blk_data and blk_last are held stable until blk_ready.
  - On handshake: clear the buffer, set p=0, then go to the next state (ACCEPT, LENBLK, or ACCEPT with counter cleared after a last block).
- The length field always equals 8×(bytes accepted) mod 2^LEN_W, zero-extended to 64 bits.
- in_empty without in_last: beat accepted and ignored (no byte, no state change).

## Timing
- Reset values:
  - in_ready=0 while rst_n low, 1 in the first cycle after release.
  - blk_valid=0, blk_last=0, blk_data=0, busy=0.
  - p=0, counter=0, state ACCEPT.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or blk_ready to any output.
- A full block, with its 64th byte accepted at edge T, gives blk_valid=1 in the cycle after T. in_ready=0 until the cycle after the blk_ready handshake.
- Last beat accepted at edge T:
  - PAD occupies cycle T+1.
  - blk_valid rises after edge T+1.
  - If a second block is needed, its blk_valid rises one cycle after the first handshake (through LENBLK).
- Throughput: 64 byte cycles + 1 EMIT cycle per full block with blk_ready held high.
- Reset asserted mid-message aborts everything immediately. No partial block is emitted after release.
- blk_valid, once high, never drops without a handshake (except by reset).

## Test plan
- "abc" (61,62,63; last on 63) -> one block 0x61626380 followed by zeros, [63:0]=0x18, blk_last=1. This is the expected ba7816bf… input for the downstream core.
- Empty message (single beat in_last=1, in_empty=1) -> one block 0x80 then zeros, length 0, blk_last=1.
- 55 bytes of 0x00 -> one block with 0x80 at byte 55, length 0x1B8, blk_last=1.
- 56 bytes -> block 1 holds the data plus 0x80 at byte 56, blk_last=0. Block 2 is all zero with length 0x1C0, blk_last=1.
- 64 bytes then an empty last beat -> block 1 is the raw data, blk_last=0. Block 2 is 0x80 then zeros with length 0x200, blk_last=1.
- Backpressure and reset:
  - blk_ready held low for 10 cycles -> blk_data/blk_last stable and in_ready=0 throughout.
  - Then rst_n pulsed low mid-message -> all outputs return to reset values immediately. A subsequent "abc" produces the correct single block.
